// File: rtl/irq_controller_if.sv
// -----------------------------------------------------------------------------
// irq_controller_if : core-side request/acknowledge and register-access bundle
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface irq_controller_if #(
  parameter int NUM_IRQ = 5
);
  logic               i_global_en;
  logic               i_mask_we;
  logic [NUM_IRQ-1:0] i_mask_wdata;
  logic               i_clr_we;
  logic [NUM_IRQ-1:0] i_clr_wdata;
  logic               i_ack;
  logic               o_irq;
  logic [2:0]         o_irq_id;
  logic [NUM_IRQ-1:0] o_pending;
  logic [NUM_IRQ-1:0] o_mask;

  modport slave (
    input  i_global_en, i_mask_we, i_mask_wdata, i_clr_we, i_clr_wdata, i_ack,
    output o_irq, o_irq_id, o_pending, o_mask
  );

  modport master (
    output i_global_en, i_mask_we, i_mask_wdata, i_clr_we, i_clr_wdata, i_ack,
    input  o_irq, o_irq_id, o_pending, o_mask
  );
endinterface

`default_nettype wire

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller : synchronizes interrupt pins, latches pending, masks and
//                  arbitrates one held request to the core.
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module irq_controller #(
  parameter int                 NUM_IRQ     = 5,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK   = {NUM_IRQ{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] i_interruption,
  irq_controller_if.slave    bus
);

  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] mask_q;
  state_t             state_q;
  logic               irq_q;
  logic [ID_W-1:0]    irq_id_q;

  logic [NUM_IRQ-1:0] s_w;
  logic [NUM_IRQ-1:0] rise_w;
  logic [NUM_IRQ-1:0] sel_w;
  logic [NUM_IRQ-1:0] sw_clr_w;
  logic [NUM_IRQ-1:0] clr_w;
  logic [NUM_IRQ-1:0] elig_w;
  logic [ID_W-1:0]    win_w;
  logic               ack_w;
  logic               sw_drop_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= i_interruption;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= s_w;
    end
  end

  assign s_w    = sync_q[SYNC_STAGES-1];
  assign rise_w = s_w & ~prev_q;

  always_comb begin
    sel_w = '0;
    for (int i = 0; i < NUM_IRQ; i++) sel_w[i] = (irq_id_q == ID_W'(i));
  end

  assign ack_w    = (state_q == REQ) && bus.i_ack;
  assign sw_clr_w = {NUM_IRQ{bus.i_clr_we}} & bus.i_clr_wdata;
  assign clr_w    = sw_clr_w | (sel_w & {NUM_IRQ{ack_w}});

  // Edge lines: a fresh rising edge beats any clear in the same cycle.
  // Level lines simply mirror the synchronized pin.
  assign pend_d = (EDGE_MASK & (rise_w | (pend_q & ~clr_w))) | (~EDGE_MASK & s_w);

  // Retract only when software actually removes the requested edge bit.
  assign sw_drop_w = |(sel_w & EDGE_MASK & sw_clr_w & ~rise_w);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (bus.i_mask_we) mask_q <= bus.i_mask_wdata;
    end
  end

  assign elig_w = pend_q & mask_q & {NUM_IRQ{bus.i_global_en}};

  always_comb begin
    win_w = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig_w[i]) win_w = ID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|elig_w) begin
            irq_id_q <= win_w;
            irq_q    <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (bus.i_ack) begin
            irq_q   <= 1'b0;
            state_q <= GAP;
          end else if (sw_drop_w) begin
            irq_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_irq     = irq_q;
  assign bus.o_irq_id  = irq_id_q;
  assign bus.o_pending = pend_q;
  assign bus.o_mask    = mask_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller : directed table, corner sequences and random run against
//                     a behavioural model for an all-edge and a line-0-level DUT.
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_irq_controller;

  localparam int          S   = 2;
  localparam logic [4:0]  EM0 = 5'b11111;
  localparam logic [4:0]  EM1 = 5'b11110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] intr = '0;
  logic       ge = 1'b1;
  logic       mwe = 1'b0;
  logic [4:0] mwd = '0;
  logic       cwe = 1'b0;
  logic [4:0] cwd = '0;
  logic       ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_controller_if #(.NUM_IRQ(5)) if0 ();
  irq_controller_if #(.NUM_IRQ(5)) if1 ();

  assign if0.i_global_en  = ge;
  assign if0.i_mask_we    = mwe;
  assign if0.i_mask_wdata = mwd;
  assign if0.i_clr_we     = cwe;
  assign if0.i_clr_wdata  = cwd;
  assign if0.i_ack        = ack;
  assign if1.i_global_en  = ge;
  assign if1.i_mask_we    = mwe;
  assign if1.i_mask_wdata = mwd;
  assign if1.i_clr_we     = cwe;
  assign if1.i_clr_wdata  = cwd;
  assign if1.i_ack        = ack;

  irq_controller #(.NUM_IRQ(5), .SYNC_STAGES(S), .EDGE_MASK(EM0)) dut0 (
    .clk(clk), .reset(rst), .i_interruption(intr), .bus(if0.slave)
  );
  irq_controller #(.NUM_IRQ(5), .SYNC_STAGES(S), .EDGE_MASK(EM1)) dut1 (
    .clk(clk), .reset(rst), .i_interruption(intr), .bus(if1.slave)
  );

  // Behavioural model: pin history queue plus per-DUT request bookkeeping.
  logic [4:0] hist[$];
  logic [4:0] m_pend [2];
  logic [4:0] m_mask [2];
  bit         m_req  [2];
  bit         m_gap  [2];
  int         m_id   [2];

  task automatic model_edge();
    logic [4:0] s, p, rise, em, elig, newp;
    if (rst) begin
      hist.delete();
      repeat (S + 1) hist.push_back(5'b0);
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = '0; m_mask[m] = '0; m_req[m] = 0; m_gap[m] = 0; m_id[m] = 0;
      end
      return;
    end
    s    = hist[S-1];
    p    = hist[S];
    rise = s & ~p;
    for (int m = 0; m < 2; m++) begin
      em   = (m == 0) ? EM0 : EM1;
      elig = m_pend[m] & m_mask[m] & {5{ge}};
      for (int i = 0; i < 5; i++) begin
        if (!em[i]) newp[i] = s[i];
        else newp[i] = rise[i] | (m_pend[m][i] & ~((cwe & cwd[i]) | (m_req[m] & ack & (m_id[m] == i))));
      end
      if (m_req[m]) begin
        if (ack) begin
          m_req[m] = 0; m_gap[m] = 1;
        end else if (cwe && cwd[m_id[m]] && em[m_id[m]] && !rise[m_id[m]]) begin
          m_req[m] = 0;
        end
      end else if (m_gap[m]) begin
        m_gap[m] = 0;
      end else if (elig != 0) begin
        m_req[m] = 1;
        m_id[m]  = $clog2(int'(elig & (~elig + 5'd1)));
      end
      if (mwe) m_mask[m] = mwd;
      m_pend[m] = newp;
    end
    hist.push_front(intr);
    void'(hist.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_irq(input int which, input int bound);
    for (int k = 0; k < bound; k++) begin
      if ((which == 0 ? if0.o_irq : if1.o_irq) === 1'b1) break;
      tick();
    end
    check("wait_irq", 32'(which == 0 ? if0.o_irq : if1.o_irq), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1; intr = '0; mwe = 0; cwe = 0; ack = 0; ge = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0] intr;
    logic       mwe;
    logic [4:0] mwd;
    logic       ack;
    logic       exp_irq;
    logic [2:0] exp_id;
    logic [4:0] exp_pend;
  } vec_t;

  vec_t tbl [25];

  initial begin
    tbl[0]  = '{5'b00000, 1'b1, 5'b11111, 1'b0, 1'b0, 3'd0, 5'b00000};
    tbl[1]  = '{5'b00100, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000};
    tbl[2]  = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b00000};
    tbl[3]  = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 5'b00100};
    tbl[4]  = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b1, 3'd2, 5'b00100};
    tbl[5]  = '{5'b00000, 1'b0, 5'b00000, 1'b1, 1'b0, 3'd2, 5'b00000};
    tbl[6]  = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd2, 5'b00000};
    tbl[7]  = '{5'b01010, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd2, 5'b00000};
    tbl[8]  = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd2, 5'b00000};
    tbl[9]  = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd2, 5'b01010};
    tbl[10] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b1, 3'd1, 5'b01010};
    tbl[11] = '{5'b00000, 1'b0, 5'b00000, 1'b1, 1'b0, 3'd1, 5'b01000};
    tbl[12] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd1, 5'b01000};
    tbl[13] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b1, 3'd3, 5'b01000};
    tbl[14] = '{5'b00000, 1'b0, 5'b00000, 1'b1, 1'b0, 3'd3, 5'b00000};
    tbl[15] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd3, 5'b00000};
    tbl[16] = '{5'b00000, 1'b1, 5'b00000, 1'b0, 1'b0, 3'd3, 5'b00000};
    tbl[17] = '{5'b10000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd3, 5'b00000};
    tbl[18] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd3, 5'b00000};
    tbl[19] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd3, 5'b10000};
    tbl[20] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd3, 5'b10000};
    tbl[21] = '{5'b00000, 1'b1, 5'b10000, 1'b0, 1'b0, 3'd3, 5'b10000};
    tbl[22] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b1, 3'd4, 5'b10000};
    tbl[23] = '{5'b00000, 1'b0, 5'b00000, 1'b1, 1'b0, 3'd4, 5'b00000};
    tbl[24] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 1'b0, 3'd4, 5'b00000};

    // Reset state
    do_reset();
    check("rst_irq",  32'(if0.o_irq), 32'd0);
    check("rst_id",   32'(if0.o_irq_id), 32'd0);
    check("rst_pend", 32'(if0.o_pending), 32'd0);
    check("rst_mask", 32'(if0.o_mask), 32'd0);

    // Directed table on the all-edge instance
    for (int v = 0; v < 25; v++) begin
      intr = tbl[v].intr; mwe = tbl[v].mwe; mwd = tbl[v].mwd; ack = tbl[v].ack;
      tick();
      check($sformatf("tbl%0d_irq", v),  32'(if0.o_irq), 32'(tbl[v].exp_irq));
      check($sformatf("tbl%0d_id", v),   32'(if0.o_irq_id), 32'(tbl[v].exp_id));
      check($sformatf("tbl%0d_pend", v), 32'(if0.o_pending), 32'(tbl[v].exp_pend));
    end
    intr = '0; mwe = 0; ack = 0;

    // Software clear retracts a live request; new edge coincident with ack survives
    do_reset();
    mwe = 1; mwd = 5'b11111; tick(); mwe = 0;
    intr = 5'b00001; tick(); intr = '0;
    wait_irq(0, 10);
    check("clr_id", 32'(if0.o_irq_id), 32'd0);
    cwe = 1; cwd = 5'b00001; tick(); cwe = 0; cwd = '0;
    check("clr_irq", 32'(if0.o_irq), 32'd0);
    check("clr_pend", 32'(if0.o_pending), 32'd0);
    tick();
    check("clr_idle", 32'(if0.o_irq), 32'd0);
    intr = 5'b00001; tick(); intr = '0;
    wait_irq(0, 10);
    intr = 5'b00001; tick(); intr = '0;
    tick();
    ack = 1; tick(); ack = 0;
    check("ackedge_irq", 32'(if0.o_irq), 32'd0);
    check("ackedge_pend", 32'(if0.o_pending), 32'd1);
    tick();
    check("ackedge_gap", 32'(if0.o_irq), 32'd0);
    tick();
    check("ackedge_rereq", 32'(if0.o_irq), 32'd1);
    check("ackedge_id", 32'(if0.o_irq_id), 32'd0);
    ack = 1; tick(); ack = 0;
    check("ackedge_done", 32'(if0.o_pending), 32'd0);

    // Level line 0 held high: re-request after each ack, then reset mid-request
    do_reset();
    mwe = 1; mwd = 5'b11111; tick(); mwe = 0;
    intr = 5'b00001;
    wait_irq(1, 10);
    check("lvl_id", 32'(if1.o_irq_id), 32'd0);
    for (int r = 0; r < 2; r++) begin
      ack = 1; tick(); ack = 0;
      check("lvl_ack_irq", 32'(if1.o_irq), 32'd0);
      check("lvl_ack_pend", 32'(if1.o_pending), 32'd1);
      tick();
      check("lvl_gap", 32'(if1.o_irq), 32'd0);
      tick();
      check("lvl_rereq", 32'(if1.o_irq), 32'd1);
    end
    rst = 1; tick(); rst = 0;
    check("rstmid_irq", 32'(if1.o_irq), 32'd0);
    check("rstmid_pend1", 32'(if1.o_pending), 32'd0);
    check("rstmid_pend0", 32'(if0.o_pending), 32'd0);
    tick(); tick();
    check("relse_early1", 32'(if1.o_pending), 32'd0);
    check("relse_early0", 32'(if0.o_pending), 32'd0);
    tick();
    check("relse_pend1", 32'(if1.o_pending), 32'd1);
    check("relse_pend0", 32'(if0.o_pending), 32'd1);
    intr = '0;

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 5; i++) if ($urandom_range(0, 5) == 0) intr[i] = ~intr[i];
      ge  = ($urandom_range(0, 9) != 0);
      mwe = ($urandom_range(0, 19) == 0);
      mwd = 5'($urandom);
      cwe = ($urandom_range(0, 9) == 0);
      cwd = 5'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      tick();
      check("rnd_dut0", 32'({if0.o_irq, if0.o_irq_id, if0.o_pending, if0.o_mask}),
            32'({m_req[0], 3'(m_id[0]), m_pend[0], m_mask[0]}));
      check("rnd_dut1", 32'({if1.o_irq, if1.o_irq_id, if1.o_pending, if1.o_mask}),
            32'({m_req[1], 3'(m_id[1]), m_pend[1], m_mask[1]}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
